// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one registered single-precision adder.
// Optional macro FP_ARB_PRIO0_EN gives requester 0 fixed top priority.
module fp_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
);
  logic [31:0] l, m;
  logic [7:0]  el, es, d, lim, nsh;
  logic [23:0] ml, ms;
  logic [4:0]  sh, lz;
  logic [55:0] msw;
  logic [26:0] al, n;
  logic [27:0] sum;
  logic [9:0]  e, ef;
  logic [24:0] mr;
  logic [22:0] fr;
  logic        sub, rup;
  logic        a_nan, b_nan, a_inf, b_inf;

  always_comb begin
    a_inf = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
    a_nan = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
    if (b[30:0] > a[30:0]) begin
      l = b;
      m = a;
    end else begin
      l = a;
      m = b;
    end
    el  = (l[30:23] == 8'd0) ? 8'd1 : l[30:23];
    es  = (m[30:23] == 8'd0) ? 8'd1 : m[30:23];
    ml  = {|l[30:23], l[22:0]};
    ms  = {|m[30:23], m[22:0]};
    d   = el - es;
    sh  = (d > 8'd31) ? 5'd31 : d[4:0];
    // guard/round bits plus a sticky OR of everything shifted out
    msw = {ms, 32'd0} >> sh;
    al  = {msw[55:30], |msw[29:0]};
    sub = l[31] ^ m[31];
    sum = sub ? ({1'b0, ml, 3'd0} - {1'b0, al})
              : ({1'b0, ml, 3'd0} + {1'b0, al});
    lz = 5'd27;
    for (int i = 0; i < 27; i++)
      if (sum[i]) lz = 5'(26 - i);
    // left shift stops at the denormal boundary
    lim = el - 8'd1;
    nsh = ({3'd0, lz} > lim) ? lim : {3'd0, lz};
    if (sum[27]) begin
      n = {sum[27:2], |sum[1:0]};
      e = {2'd0, el} + 10'd1;
    end else begin
      n = sum[26:0] << nsh;
      e = {2'd0, el} - {2'd0, nsh};
    end
    rup = n[2] & (n[1] | n[0] | n[3]);
    mr  = {1'b0, n[26:3]} + {24'd0, rup};
    if (mr[24]) begin
      ef = e + 10'd1;
      fr = mr[23:1];
    end else begin
      ef = mr[23] ? e : 10'd0;
      fr = mr[22:0];
    end
    if (a_nan | b_nan | (a_inf & b_inf & (a[31] ^ b[31])))
      s = 32'h7fc00000;
    else if (a_inf | b_inf)
      s = {a_inf ? a[31] : b[31], 8'hff, 23'd0};
    else if (sum == 28'd0)
      s = {~sub & l[31], 31'd0};
    else if (ef >= 10'd255)
      s = {l[31], 8'hff, 23'd0};
    else
      s = {l[31], ef[7:0], fr};
  end
endmodule

module fp_add_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_sum,
  input  logic               rsp_ready,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr, grant, idx, id_q;
  logic [31:0]    op_a, op_b, s;
  logic           any, accept;

  fp_adder u_add (.a(op_a), .b(op_b), .s(s));

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    // descending scan so the nearest index after rr_ptr wins
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (req_valid[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
`ifdef FP_ARB_PRIO0_EN
    if (req_valid[0]) grant = '0;
`else
`endif
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: if (any) begin
        req_ready = NREQ'(1) << grant;
        accept    = 1'b1;
        state_d   = EXEC;
      end
      EXEC: state_d = HOLD;
      HOLD: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!rst_n) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      op_a      <= '0;
      op_b      <= '0;
      id_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_a   <= req_a[32*grant +: 32];
        op_b   <= req_b[32*grant +: 32];
        id_q   <= grant;
        rr_ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
      end
      if (state_q == EXEC) begin
        rsp_sum   <= s;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end
      if (state_q == HOLD && rsp_ready) rsp_valid <= 1'b0;
    end
  end

  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter.
// Build with FP_ARB_PRIO0_EN defined to exercise priority mode.
module tb_fp_add_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam logic [31:0] T3A [4] =
    '{32'h440d491c, 32'h40000000, 32'h3fffffff, 32'h00012832};
  localparam logic [31:0] T3B [4] =
    '{32'h00000000, 32'h34000000, 32'h34000000, 32'h0014283c};
  localparam logic [31:0] T3S [4] =
    '{32'h440d491c, 32'h40000000, 32'h40000000, 32'h0015506e};

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*32-1:0] req_a = '0;
  logic [NREQ*32-1:0] req_b = '0;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_sum;
  logic               rsp_ready = 1'b1;
  logic               busy;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  fp_add_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic setop(input int i, input logic [31:0] a,
                       input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  initial begin
    int g;
    // reset held three cycles with every requester asking
    req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end
    chk("rst_rsp_sum", rsp_sum, 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("first_grant", 32'(req_ready), 32'h1);
    req_valid = 4'b0000;

    // requester 2 alone
    cyc();
    req_valid = 4'b0100;
    setop(2, 32'h3f800001, 32'hbf800000);
    #1;
    chk("t2_grant", 32'(req_ready), 32'h4);
    cyc(); #1;
    req_valid = 4'b0000;
    chk("t2_exec_busy", 32'(busy), 32'h1);
    chk("t2_exec_valid", 32'(rsp_valid), 32'h0);
    cyc(); #1;
    chk("t2_valid", 32'(rsp_valid), 32'h1);
    chk("t2_id", 32'(rsp_id), 32'h2);
    chk("t2_sum", rsp_sum, 32'h34000000);
    cyc(); #1;
    chk("t2_idle_busy", 32'(busy), 32'h0);
    chk("t2_idle_valid", 32'(rsp_valid), 32'h0);

    // reset during EXEC drops the op
    req_valid = 4'b0010;
    setop(1, 32'h40000000, 32'h34000000);
    #1;
    chk("t5_grant", 32'(req_ready), 32'h2);
    cyc(); #1;
    chk("t5_exec_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("t5_rst_valid", 32'(rsp_valid), 32'h0);
      chk("t5_rst_busy", 32'(busy), 32'h0);
      chk("t5_rst_ready", 32'(req_ready), 32'h0);
    end
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) setop(i, T3A[i], T3B[i]);
    #1;
    chk("t5_after_grant", 32'(req_ready), 32'h1);

    // all four valid continuously
    for (int k = 0; k < 5; k++) begin
`ifdef FP_ARB_PRIO0_EN
      g = 0;
`else
      g = k % 4;
`endif
      chk("t3_grant", 32'(req_ready), 32'(1) << g);
      cyc(); #1;
      chk("t3_exec_ready", 32'(req_ready), 32'h0);
      chk("t3_exec_valid", 32'(rsp_valid), 32'h0);
      cyc(); #1;
      chk("t3_valid", 32'(rsp_valid), 32'h1);
      chk("t3_id", 32'(rsp_id), 32'(g));
      chk("t3_sum", rsp_sum, T3S[g]);
      chk("t3_hold_ready", 32'(req_ready), 32'h0);
      cyc(); #1;
      chk("t3_idle_valid", 32'(rsp_valid), 32'h0);
    end

`ifndef FP_ARB_PRIO0_EN
    // backpressure in HOLD; rr_ptr is 1 here
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    setop(1, 32'h3fc00000, 32'h3fc00000);
    #1;
    chk("t4_grant", 32'(req_ready), 32'h2);
    cyc(); #1;
    req_valid = 4'b1111;
    cyc(); #1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid", 32'(rsp_valid), 32'h1);
      chk("t4_id", 32'(rsp_id), 32'h1);
      chk("t4_sum", rsp_sum, 32'h40400000);
      chk("t4_ready", 32'(req_ready), 32'h0);
      chk("t4_busy", 32'(busy), 32'h1);
      cyc(); #1;
    end
    rsp_ready = 1'b1;
    cyc(); #1;
    chk("t4_idle_busy", 32'(busy), 32'h0);
    chk("t4_idle_valid", 32'(rsp_valid), 32'h0);
    chk("t4_next_grant", 32'(req_ready), 32'h4);
    req_valid = 4'b0000;
`else
    // priority: requester 0 wins every op against requester 3
    cyc();
    req_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t6_prio_grant", 32'(req_ready), 32'h1);
      cyc(); cyc(); #1;
      chk("t6_prio_id", 32'(rsp_id), 32'h0);
      cyc();
    end
    req_valid = 4'b1000;
    #1;
    chk("t6_drop_grant", 32'(req_ready), 32'h8);
    cyc(); cyc(); #1;
    chk("t6_drop_id", 32'(rsp_id), 32'h3);
    chk("t6_drop_sum", rsp_sum, T3S[3]);
    req_valid = 4'b0000;
`endif
    cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
